// File: rtl/muldiv_unit.sv
// Multi-cycle HI/LO multiply/divide unit for the EX stage; owns the HI/LO registers
// and raises stall while a dependent HI/LO instruction waits in ID.
module muldiv_unit #(
  parameter int unsigned MUL_CYCLES = 4,
  parameter int unsigned WIDTH      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             rd_req_i,
  input  logic             cancel_i,
  output logic             busy_o,
  output logic             stall_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned CntMax = (MUL_CYCLES > WIDTH + 1) ? MUL_CYCLES : WIDTH + 1;
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             sgn_q, sgn_d;      // signed variant (MULT/DIV)
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;

  logic             a_neg_in, b_neg_in;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic             q_neg, r_neg;

  assign a_neg_in = ~op_i[0] & a_i[WIDTH-1];
  assign b_neg_in = ~op_i[0] & b_i[WIDTH-1];

  // Sign-extending to 2*WIDTH makes one unsigned multiply correct for both variants.
  assign prod = {{WIDTH{sgn_q & a_q[WIDTH-1]}}, a_q} * {{WIDTH{sgn_q & b_q[WIDTH-1]}}, b_q};

  // Restoring divide step; the low WIDTH bits of the difference are exact when rem_ge.
  assign rem_sh  = {rem_q, quo_q[WIDTH-1]};
  assign rem_sub = rem_sh[WIDTH-1:0] - dvs_q;
  assign rem_ge  = rem_sh >= {1'b0, dvs_q};

  assign q_neg = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
  assign r_neg = sgn_q & a_q[WIDTH-1];

  // Next-state and HI/LO update logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && !cancel_i) begin
          // start wins over a same-cycle MTHI/MTLO
          state_d = op_i[1] ? StDiv : StMul;
          cnt_d   = '0;
          sgn_d   = ~op_i[0];
          a_d     = a_i;
          b_d     = b_i;
          rem_d   = '0;
          quo_d   = a_neg_in ? -a_i : a_i;
          dvs_d   = b_neg_in ? -b_i : b_i;
        end else if (!cancel_i) begin
          if (hi_we_i) hi_d = wdata_i;
          if (lo_we_i) lo_d = wdata_i;
        end
      end
      StMul: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(MUL_CYCLES - 1)) begin
          state_d = StIdle;
          if (!cancel_i) {hi_d, lo_d} = prod;
        end
      end
      StDiv: begin
        rem_d = rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], rem_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        if (!cancel_i) begin
          if (b_q == '0) begin
            lo_d = '1;
            hi_d = a_q;
          end else begin
            lo_d = q_neg ? -quo_q : quo_q;
            hi_d = r_neg ? -rem_q : rem_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (cancel_i && state_q != StIdle) state_d = StIdle;
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sgn_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sgn_q   <= sgn_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign stall_o = busy_o & (start_i | rd_req_i | hi_we_i | lo_we_i);
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with hand-computed HI/LO results and cycle counts.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i, start_i, hi_we_i, lo_we_i, rd_req_i, cancel_i;
  logic [1:0]  op_i;
  logic [31:0] a_i, b_i, wdata_i;
  logic        busy_o, stall_o;
  logic [31:0] hi_o, lo_o;

  int checks   = 0;
  int failures = 0;

  muldiv_unit #(.MUL_CYCLES(4), .WIDTH(32)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .op_i    (op_i),
    .a_i     (a_i),
    .b_i     (b_i),
    .hi_we_i (hi_we_i),
    .lo_we_i (lo_we_i),
    .wdata_i (wdata_i),
    .rd_req_i(rd_req_i),
    .cancel_i(cancel_i),
    .busy_o  (busy_o),
    .stall_o (stall_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Launch an op and count busy cycles until busy falls (bounded).
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cyc);
    start_i = 1'b1; op_i = op; a_i = a; b_i = b;
    tick();
    start_i = 1'b0;
    cyc = 0;
    while (busy_o && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  task automatic mt(input logic [31:0] hv, input logic [31:0] lv);
    hi_we_i = 1'b1; wdata_i = hv; tick(); hi_we_i = 1'b0;
    lo_we_i = 1'b1; wdata_i = lv; tick(); lo_we_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; tick(); tick(); rst_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b want 0", busy_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got %0b want 0", stall_o); end
    checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL reset_hi got %h want 0", hi_o); end
    checks++; if (lo_o !== 32'h0) begin failures++; $display("FAIL reset_lo got %h want 0", lo_o); end
  endtask

  task automatic test_mthi_mtlo();
    mt(32'h0000_1234, 32'h0000_5678);
    checks++; if (hi_o !== 32'h1234) begin failures++; $display("FAIL mthi got %h want 1234", hi_o); end
    checks++; if (lo_o !== 32'h5678) begin failures++; $display("FAIL mtlo got %h want 5678", lo_o); end
    rd_req_i = 1'b1; #1;
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL idle_rd_stall got %0b want 0", stall_o); end
    rd_req_i = 1'b0;
  endtask

  task automatic test_mult();
    int cyc;
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, cyc);
    checks++; if (cyc != 4) begin failures++; $display("FAIL mult_cycles got %0d want 4", cyc); end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL mult_hi got %h want ffffffff", hi_o); end
    checks++; if (lo_o !== 32'hFFFF_FFEB) begin failures++; $display("FAIL mult_lo got %h want ffffffeb", lo_o); end
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, cyc);
    checks++; if (cyc != 4) begin failures++; $display("FAIL multu_cycles got %0d want 4", cyc); end
    checks++; if (hi_o !== 32'hFFFF_FFFE) begin failures++; $display("FAIL multu_hi got %h want fffffffe", hi_o); end
    checks++; if (lo_o !== 32'h0000_0001) begin failures++; $display("FAIL multu_lo got %h want 1", lo_o); end
  endtask

  task automatic test_div();
    int cyc;
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, cyc);
    checks++; if (cyc != 33) begin failures++; $display("FAIL div_cycles got %0d want 33", cyc); end
    checks++; if (lo_o !== 32'hFFFF_FFFD) begin failures++; $display("FAIL div_lo got %h want fffffffd", lo_o); end
    checks++; if (hi_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div_hi got %h want ffffffff", hi_o); end
    run_op(2'b11, 32'd100, 32'd7, cyc);
    checks++; if (lo_o !== 32'd14) begin failures++; $display("FAIL divu_lo got %h want e", lo_o); end
    checks++; if (hi_o !== 32'd2) begin failures++; $display("FAIL divu_hi got %h want 2", hi_o); end
    run_op(2'b11, 32'd5, 32'd0, cyc);
    checks++; if (cyc != 33) begin failures++; $display("FAIL div0_cycles got %0d want 33", cyc); end
    checks++; if (lo_o !== 32'hFFFF_FFFF) begin failures++; $display("FAIL div0_lo got %h want ffffffff", lo_o); end
    checks++; if (hi_o !== 32'd5) begin failures++; $display("FAIL div0_hi got %h want 5", hi_o); end
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, cyc);
    checks++; if (lo_o !== 32'h8000_0000) begin failures++; $display("FAIL divovf_lo got %h want 80000000", lo_o); end
    checks++; if (hi_o !== 32'h0) begin failures++; $display("FAIL divovf_hi got %h want 0", hi_o); end
  endtask

  task automatic test_operand_latch();
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd6; b_i = 32'd7;
    tick();
    start_i = 1'b0; a_i = 32'd0; b_i = 32'd0;
    for (int i = 0; i < 4; i++) tick();
    checks++; if (lo_o !== 32'd42) begin failures++; $display("FAIL latch_lo got %h want 2a", lo_o); end
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL latch_busy got %0b want 0", busy_o); end
  endtask

  task automatic test_stall();
    int cyc;
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd5;
    tick();                                  // busy cycle 1
    start_i = 1'b0;
    tick(); tick();                          // busy cycle 3
    rd_req_i = 1'b1; #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rd_stall_c3 got %0b want 1", stall_o); end
    tick();                                  // busy cycle 4
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL rd_stall_c4 got %0b want 1", stall_o); end
    tick();
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL rd_stall_end got %0b want 0", stall_o); end
    checks++; if (lo_o !== 32'd15) begin failures++; $display("FAIL rd_lo got %h want f", lo_o); end
    rd_req_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    int cyc;
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd2; b_i = 32'd9;
    tick();
    // Next op held in ID/EX while busy
    op_i = 2'b11; a_i = 32'd100; b_i = 32'd7; #1;
    checks++; if (stall_o !== 1'b1) begin failures++; $display("FAIL b2b_stall got %0b want 1", stall_o); end
    cyc = 0;
    while (busy_o && cyc < 100) begin cyc++; tick(); end
    checks++; if (cyc != 4) begin failures++; $display("FAIL b2b_first_cycles got %0d want 4", cyc); end
    checks++; if (lo_o !== 32'd18) begin failures++; $display("FAIL b2b_first_lo got %h want 12", lo_o); end
    checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL b2b_idle_stall got %0b want 0", stall_o); end
    tick();
    start_i = 1'b0;
    checks++; if (busy_o !== 1'b1) begin failures++; $display("FAIL b2b_accept got %0b want 1", busy_o); end
    cyc = 1;
    while (busy_o && cyc < 100) begin cyc++; tick(); end
    checks++; if (cyc != 34) begin failures++; $display("FAIL b2b_second_cycles got %0d want 34", cyc - 1 + 1); end
    checks++; if (lo_o !== 32'd14 || hi_o !== 32'd2) begin
      failures++; $display("FAIL b2b_second_result got hi=%h lo=%h want hi=2 lo=e", hi_o, lo_o);
    end
  endtask

  task automatic test_start_wins();
    int cyc;
    hi_we_i = 1'b1; lo_we_i = 1'b1; wdata_i = 32'hAAAA_AAAA;
    run_op(2'b01, 32'd2, 32'd3, cyc);
    hi_we_i = 1'b0; lo_we_i = 1'b0;
    checks++; if (hi_o !== 32'd0 || lo_o !== 32'd6) begin
      failures++; $display("FAIL start_wins got hi=%h lo=%h want hi=0 lo=6", hi_o, lo_o);
    end
  endtask

  task automatic test_cancel();
    mt(32'h0000_0011, 32'h0000_0022);
    start_i = 1'b1; op_i = 2'b11; a_i = 32'd100; b_i = 32'd7;
    tick(); start_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();    // busy cycle 10
    cancel_i = 1'b1; tick(); cancel_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL cancel_busy got %0b want 0", busy_o); end
    checks++; if (hi_o !== 32'h11 || lo_o !== 32'h22) begin
      failures++; $display("FAIL cancel_keep got hi=%h lo=%h want hi=11 lo=22", hi_o, lo_o);
    end
    start_i = 1'b1; op_i = 2'b01; a_i = 32'd3; b_i = 32'd5;
    tick(); start_i = 1'b0;
    tick(); tick(); tick();                  // busy cycle 4, completion
    cancel_i = 1'b1; tick(); cancel_i = 1'b0;
    checks++; if (busy_o !== 1'b0 || hi_o !== 32'h11 || lo_o !== 32'h22) begin
      failures++; $display("FAIL cancel_at_done got busy=%0b hi=%h lo=%h want busy=0 hi=11 lo=22",
                           busy_o, hi_o, lo_o);
    end
    start_i = 1'b1; cancel_i = 1'b1; tick(); start_i = 1'b0; cancel_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL cancel_start got %0b want 0", busy_o); end
  endtask

  task automatic test_reset_mid();
    mt(32'h0000_0033, 32'h0000_0044);
    start_i = 1'b1; op_i = 2'b10; a_i = 32'd100; b_i = 32'd7;
    tick(); start_i = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL rstmid_busy got %0b want 0", busy_o); end
    checks++; if (hi_o !== 32'h0 || lo_o !== 32'h0) begin
      failures++; $display("FAIL rstmid_hilo got hi=%h lo=%h want 0/0", hi_o, lo_o);
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; op_i = 2'b00; a_i = '0; b_i = '0;
    hi_we_i = 1'b0; lo_we_i = 1'b0; wdata_i = '0; rd_req_i = 1'b0; cancel_i = 1'b0;
    test_reset();
    test_mthi_mtlo();
    test_mult();
    test_div();
    test_operand_latch();
    test_stall();
    test_back_to_back();
    test_start_wins();
    test_cancel();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
